// File: rtl/i2c_byte_master_if.sv
// rtl/i2c_byte_master_if.sv - command/response and pad-side signal bundle for the I2C byte master
// Purpose: groups the command request, byte response, SCL driver hold/phase and
//   SDA open-drain signals so the master and its neighbours connect through one port.
// Signals:
//   cmd_valid/cmd_ready      command handshake (accept when both high)
//   cmd_start/stop/read/nack command qualifiers, cmd_data write byte (MSB first)
//   rsp_valid                one-cycle pulse when a byte completes
//   rsp_data/rsp_nack        read byte / slave NACK on write
//   busy                     high from accept until the master is back in IDLE
//   scl_hold/scl_cnt         SCL driver enable (1 = SCL released, counter held) and phase count
//   sda_oe/sda_in            SDA pull-low enable and SDA pad value
// Modports: master = the byte master, slave = the front end / pad side that faces it.
interface i2c_byte_master_if #(
  parameter int DIV_LEN = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_start;
  logic               cmd_stop;
  logic               cmd_read;
  logic               cmd_nack;
  logic [7:0]         cmd_data;
  logic               rsp_valid;
  logic [7:0]         rsp_data;
  logic               rsp_nack;
  logic               busy;
  logic               scl_hold;
  logic [DIV_LEN-1:0] scl_cnt;
  logic               sda_oe;
  logic               sda_in;

  modport master (
    input  cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_nack, cmd_data, scl_cnt, sda_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack, busy, scl_hold, sda_oe
  );

  modport slave (
    output cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_nack, cmd_data, scl_cnt, sda_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack, busy, scl_hold, sda_oe
  );
endinterface

// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - byte-level I2C master sequencer (START / write / read / STOP)
// Purpose: executes one byte command at a time on an I2C bus, using an external
//   SCL clock driver (enabled through scl_hold, phase read back on scl_cnt) and
//   an open-drain SDA (sda_oe pulls low).
// Ports:
//   clk   system clock, all state on posedge
//   rstn  synchronous active-low reset
//   bus   i2c_byte_master_if.master: cmd_* request, rsp_* response, busy,
//         scl_hold/scl_cnt driver link, sda_oe/sda_in pad link
module i2c_byte_master #(
  parameter int CLK_DIV  = 8,
  parameter int CLK_DUTY = 4,
  parameter int DIV_LEN  = 16
) (
  input logic               clk,
  input logic               rstn,
  i2c_byte_master_if.master bus
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_START_REL = 4'd1;  // SDA released, SCL high
  localparam logic [3:0] ST_START_LOW = 4'd2;  // SDA low with SCL high: START edge
  localparam logic [3:0] ST_BIT       = 4'd3;
  localparam logic [3:0] ST_ACK       = 4'd4;
  localparam logic [3:0] ST_HOLD      = 4'd5;
  localparam logic [3:0] ST_STOP_LOW  = 4'd6;  // one SCL period with SDA low
  localparam logic [3:0] ST_STOP_HIGH = 4'd7;  // SCL held high, SDA still low
  localparam logic [3:0] ST_STOP_REL  = 4'd8;  // SDA released: STOP edge, then bus free

  logic [3:0]         state;
  logic [DIV_LEN-1:0] tcnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               rd_q;
  logic               nack_q;
  logic               stop_q;
  logic               rdy_en;
  logic               rsp_valid_q;
  logic [7:0]         rsp_data_q;
  logic               rsp_nack_q;
  logic               period_end;
  logic               duty_end;
  logic               accept;

  // The driver counter only runs while scl_hold=0; the START/STOP phases hold
  // SCL high and time themselves with the local tcnt instead.
  assign period_end = (bus.scl_cnt == DIV_LEN'(CLK_DIV - 1));
  assign duty_end   = (tcnt == DIV_LEN'(CLK_DUTY - 1));

  // In HOLD a command is only taken at the last count of a period, so the next
  // phase (START with SCL high, or a bit with SCL low) follows without a glitch.
  // rdy_en keeps ready low while in reset and for the cycle it is released.
  assign bus.cmd_ready = rdy_en & ((state == ST_IDLE) | ((state == ST_HOLD) & period_end));
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_nack  = rsp_nack_q;

  always_comb begin
    bus.scl_hold = 1'b0;
    bus.sda_oe   = 1'b0;
    case (state)
      ST_IDLE, ST_START_REL, ST_STOP_REL: begin
        bus.scl_hold = 1'b1;
      end
      ST_START_LOW, ST_STOP_HIGH: begin
        bus.scl_hold = 1'b1;
        bus.sda_oe   = 1'b1;
      end
      ST_BIT:      bus.sda_oe = ~rd_q & ~shreg[7];
      ST_ACK:      bus.sda_oe = rd_q & ~nack_q;
      ST_STOP_LOW: bus.sda_oe = 1'b1;
      default: begin
        bus.scl_hold = 1'b0;
        bus.sda_oe   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      tcnt        <= '0;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      rd_q        <= 1'b0;
      nack_q      <= 1'b0;
      stop_q      <= 1'b0;
      rdy_en      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_nack_q  <= 1'b0;
    end else begin
      rdy_en      <= 1'b1;
      rsp_valid_q <= 1'b0;

      // Accepts only happen in IDLE/HOLD, where nothing else touches these.
      if (accept) begin
        shreg  <= bus.cmd_data;
        rd_q   <= bus.cmd_read;
        nack_q <= bus.cmd_nack;
        stop_q <= bus.cmd_stop;
      end

      case (state)
        ST_IDLE: begin
          // A command without START cannot be issued on a free bus: drop it.
          if (accept && bus.cmd_start) begin
            state <= ST_START_REL;
            tcnt  <= '0;
          end
        end

        ST_HOLD: begin
          if (accept) begin
            tcnt    <= '0;
            bit_cnt <= 3'd7;
            state   <= bus.cmd_start ? ST_START_REL : ST_BIT;
          end
        end

        // The release phase is what makes a repeated START valid: SDA must be
        // high while SCL is high before it is pulled low. From IDLE it is a
        // harmless extra bus-free interval.
        ST_START_REL: begin
          if (duty_end) begin
            tcnt  <= '0;
            state <= ST_START_LOW;
          end else begin
            tcnt <= tcnt + DIV_LEN'(1);
          end
        end

        ST_START_LOW: begin
          if (duty_end) begin
            tcnt    <= '0;
            bit_cnt <= 3'd7;
            state   <= ST_BIT;
          end else begin
            tcnt <= tcnt + DIV_LEN'(1);
          end
        end

        // Shifting at the sample point moves the next bit onto SDA exactly when
        // the driver wraps to 0 (SCL low). Reads collect sda_in at the LSB.
        ST_BIT: begin
          if (period_end) begin
            shreg <= {shreg[6:0], bus.sda_in};
            if (bit_cnt == 3'd0) begin
              state <= ST_ACK;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
        end

        ST_ACK: begin
          if (period_end) begin
            rsp_valid_q <= 1'b1;
            if (rd_q) begin
              rsp_data_q <= shreg;
              rsp_nack_q <= 1'b0;
            end else begin
              rsp_nack_q <= bus.sda_in;
            end
            state <= stop_q ? ST_STOP_LOW : ST_HOLD;
          end
        end

        ST_STOP_LOW: begin
          if (period_end) begin
            tcnt  <= '0;
            state <= ST_STOP_HIGH;
          end
        end

        ST_STOP_HIGH: begin
          if (duty_end) begin
            tcnt  <= '0;
            state <= ST_STOP_REL;
          end else begin
            tcnt <= tcnt + DIV_LEN'(1);
          end
        end

        ST_STOP_REL: begin
          if (duty_end) begin
            tcnt  <= '0;
            state <= ST_IDLE;
          end else begin
            tcnt <= tcnt + DIV_LEN'(1);
          end
        end

        default: begin
          tcnt  <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - self-checking bench for i2c_byte_master with SCL driver and slave models
module tb_i2c_byte_master;
  localparam int DIV     = 8;
  localparam int DUTY    = 4;
  localparam int DLEN    = 16;
  localparam int TXN_CYC = 2*DUTY + 9*DIV + DIV + 2*DUTY;  // 96

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  i2c_byte_master_if #(.DIV_LEN(DLEN)) bus ();

  i2c_byte_master #(
    .CLK_DIV (DIV),
    .CLK_DUTY(DUTY),
    .DIV_LEN (DLEN)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // SCL clock driver: counter held at 0 while scl_hold, else free-running 0..DIV-1
  logic [DLEN-1:0] drv_cnt = '0;
  always @(posedge clk) begin
    if (!rstn || bus.scl_hold) drv_cnt <= '0;
    else if (drv_cnt == DLEN'(DIV - 1)) drv_cnt <= '0;
    else drv_cnt <= drv_cnt + DLEN'(1);
  end

  logic scl;
  logic sda;
  logic slv_pull = 1'b0;
  assign scl         = bus.scl_hold | (drv_cnt >= DLEN'(DUTY));
  assign sda         = ~(bus.sda_oe | slv_pull);
  assign bus.scl_cnt = drv_cnt;
  assign bus.sda_in  = sda;

  // Slave model: byte counter restarted at START, driven bits change on SCL fall
  logic       slv_tx_mode = 1'b0;
  logic [7:0] slv_tx_byte = 8'h00;
  logic       slv_ack_en  = 1'b0;
  logic       scl_q = 1'b1, sda_q = 1'b1;
  logic       slv_active = 1'b0, slv_txmode = 1'b0, slv_ackbit = 1'b0;
  logic [3:0] slv_bit = 4'd0;
  logic [7:0] slv_rx = 8'h00, slv_txsh = 8'h00;
  int         starts = 0, stops = 0;

  always @(negedge clk) begin
    scl_q <= scl;
    sda_q <= sda;
    if (scl_q && scl && sda_q && !sda) begin
      starts     <= starts + 1;
      slv_active <= 1'b1;
      slv_bit    <= 4'd0;
      slv_pull   <= 1'b0;
      slv_txmode <= slv_tx_mode;
      slv_txsh   <= slv_tx_byte;
    end else if (scl_q && scl && !sda_q && sda) begin
      stops      <= stops + 1;
      slv_active <= 1'b0;
      slv_pull   <= 1'b0;
    end else if (slv_active && !scl_q && scl) begin
      if (slv_bit < 4'd8) slv_rx <= {slv_rx[6:0], sda};
      else slv_ackbit <= sda;
      slv_bit <= slv_bit + 4'd1;
    end else if (slv_active && scl_q && !scl) begin
      if (slv_bit == 4'd9) begin
        slv_active <= 1'b0;
        slv_pull   <= 1'b0;
      end else if (slv_txmode && slv_bit < 4'd8) begin
        slv_pull <= ~slv_txsh[3'd7 - slv_bit[2:0]];
      end else if (!slv_txmode && slv_bit == 4'd8) begin
        slv_pull <= slv_ack_en;
      end else begin
        slv_pull <= 1'b0;
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic s, input logic p, input logic r, input logic n,
                      input logic [7:0] d, output logic ok);
    bus.cmd_start = s;
    bus.cmd_stop  = p;
    bus.cmd_read  = r;
    bus.cmd_nack  = n;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       stop;
    logic       rd;
    logic       nack;
    logic [7:0] data;
    logic       slv_ack;
    logic [7:0] slv_byte;
    logic       exp_nack;
    logic [7:0] exp_data;
    logic [7:0] exp_rx;
    logic       exp_ackbit;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx, input vec_t v);
    int   s0, p0, cyc, pulses, post;
    logic ok, done;
    slv_tx_mode = v.rd;
    slv_tx_byte = v.slv_byte;
    slv_ack_en  = v.slv_ack;
    s0 = starts;
    p0 = stops;
    send(v.start, v.stop, v.rd, v.nack, v.data, ok);
    check($sformatf("v%0d_accept", idx), {31'd0, ok}, 32'd1);
    cyc = 0; pulses = 0; post = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (bus.busy) cyc++;
      if (bus.rsp_valid) pulses++;
      if (v.stop) done = !bus.busy;
      else if (pulses > 0) begin
        post++;
        done = (post > 4);
      end
      if (!done) @(negedge clk);
    end
    check($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
    check($sformatf("v%0d_rsp_pulses", idx), pulses, 32'd1);
    check($sformatf("v%0d_starts", idx), starts - s0, 32'd1);
    check($sformatf("v%0d_stops", idx), stops - p0, {31'd0, v.stop});
    check($sformatf("v%0d_wire_byte", idx), {24'd0, slv_rx}, {24'd0, v.exp_rx});
    if (v.rd) begin
      check($sformatf("v%0d_rsp_data", idx), {24'd0, bus.rsp_data}, {24'd0, v.exp_data});
      check($sformatf("v%0d_master_ack", idx), {31'd0, slv_ackbit}, {31'd0, v.exp_ackbit});
    end else begin
      check($sformatf("v%0d_rsp_nack", idx), {31'd0, bus.rsp_nack}, {31'd0, v.exp_nack});
    end
    if (v.stop) begin
      check($sformatf("v%0d_busy_cycles", idx), cyc, TXN_CYC);
      check($sformatf("v%0d_idle_scl_hold", idx), {31'd0, bus.scl_hold}, 32'd1);
    end else begin
      check($sformatf("v%0d_hold_busy", idx), {31'd0, bus.busy}, 32'd1);
      check($sformatf("v%0d_hold_scl_hold", idx), {31'd0, bus.scl_hold}, 32'd0);
    end
    check($sformatf("v%0d_sda_released", idx), {31'd0, bus.sda_oe}, 32'd0);
  endtask

  initial begin
    logic ok;
    int   pulses;
    //          start stop rd   nack data   sack slv    enack edata  erx    eack
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b1, 8'h00, 8'h3C, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h5A, 1'b0, 8'h5A, 8'h5A, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h90, 1'b1, 8'h00, 1'b0, 8'h00, 8'h90, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'hC3, 1'b0, 8'hC3, 8'hC3, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h81, 1'b0, 8'h81, 8'h81, 1'b0};

    // Reset with a pending request
    bus.cmd_valid = 1'b1;
    bus.cmd_start = 1'b1;
    bus.cmd_stop  = 1'b1;
    bus.cmd_read  = 1'b0;
    bus.cmd_nack  = 1'b0;
    bus.cmd_data  = 8'hFF;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scl_hold", {31'd0, bus.scl_hold}, 32'd1);
    check("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
    rstn = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_release_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Command without START from IDLE is dropped
    bus.cmd_start = 1'b0;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("nostart_busy", {31'd0, bus.busy}, 32'd0);
    check("nostart_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("nostart_scl_hold", {31'd0, bus.scl_hold}, 32'd1);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset during bit 4 of a write of 0x0F (bit 4 = 0, SDA pulled)
    slv_tx_mode = 1'b0;
    send(1'b1, 1'b1, 1'b0, 1'b0, 8'h0F, ok);
    check("midrst_accept", {31'd0, ok}, 32'd1);
    repeat (34) @(negedge clk);
    check("midrst_pre_sda_oe", {31'd0, bus.sda_oe}, 32'd1);
    check("midrst_pre_scl_hold", {31'd0, bus.scl_hold}, 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_scl_hold", {31'd0, bus.scl_hold}, 32'd1);
    check("midrst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("midrst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    check("midrst_no_rsp", pulses, 32'd0);
    check("midrst_ready", {31'd0, bus.cmd_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
